// File: rtl/exec_pkg.sv
`default_nettype none
// ============================================================================
// Module      : exec_pkg
// Description : Shared ALU opcode and multi-cycle FSM state encodings.
// Revision    : 1.0 - initial release
// ============================================================================
package exec_pkg;

    localparam logic [2:0] OP_ADD  = 3'd0;
    localparam logic [2:0] OP_SUB  = 3'd1;
    localparam logic [2:0] OP_SLT  = 3'd2;
    localparam logic [2:0] OP_BEQ  = 3'd3;
    localparam logic [2:0] OP_DIV  = 3'd4;
    localparam logic [2:0] OP_XOR  = 3'd5;
    localparam logic [2:0] OP_BNE  = 3'd6;
    localparam logic [2:0] OP_SLTU = 3'd7;

    localparam logic [1:0] ST_IDLE     = 2'd0;
    localparam logic [1:0] ST_DIV_BUSY = 2'd1;
    localparam logic [1:0] ST_DIV_DONE = 2'd2;

endpackage
`default_nettype wire

// File: rtl/div_iter.sv
`default_nettype none
// ============================================================================
// Module      : div_iter
// Description : Iterative restoring unsigned divider, one quotient bit/cycle.
// Revision    : 1.0 - initial release
// ============================================================================
module div_iter #(
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_start,
    input  logic              i_abort,
    input  logic [DATA_W-1:0] i_dividend,
    input  logic [DATA_W-1:0] i_divisor,
    output logic              o_done,
    output logic [DATA_W-1:0] o_quot,
    output logic [DATA_W-1:0] o_rem
);
    import exec_pkg::*;

    localparam int            CNT_W  = $clog2(DATA_W);
    localparam logic [CNT_W-1:0] c_LAST = CNT_W'(DATA_W - 1);

    logic              r_busy;
    logic [CNT_W-1:0]  r_cnt;
    logic [DATA_W-1:0] r_rem;
    logic [DATA_W-1:0] r_quo;
    logic [DATA_W-1:0] r_dvs;

    logic [DATA_W:0]   w_shift;
    logic [DATA_W:0]   w_diff;
    logic              w_ge;

    // Dividend bits shift out of r_quo's MSB while quotient bits shift in at the LSB.
    // A zero divisor always succeeds the trial, giving all-ones quotient and rem = dividend.
    assign w_shift = {r_rem, r_quo[DATA_W-1]};
    assign w_diff  = w_shift - {1'b0, r_dvs};
    assign w_ge    = ~w_diff[DATA_W];

    assign o_done  = r_busy && (r_cnt == c_LAST);
    assign o_quot  = r_quo;
    assign o_rem   = r_rem;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_busy <= 1'b0;
            r_cnt  <= '0;
            r_rem  <= '0;
            r_quo  <= '0;
            r_dvs  <= '0;
        end else if (i_abort) begin
            r_busy <= 1'b0;
            r_cnt  <= '0;
        end else if (i_start) begin
            r_busy <= 1'b1;
            r_cnt  <= '0;
            r_rem  <= '0;
            r_quo  <= i_dividend;
            r_dvs  <= i_divisor;
        end else if (r_busy) begin
            r_rem  <= w_ge ? w_diff[DATA_W-1:0] : w_shift[DATA_W-1:0];
            r_quo  <= {r_quo[DATA_W-2:0], w_ge};
            if (r_cnt == c_LAST) begin
                r_busy <= 1'b0;
                r_cnt  <= '0;
            end else begin
                r_cnt  <= r_cnt + 1'b1;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/exec_unit_mc.sv
`default_nettype none
// ============================================================================
// Module      : exec_unit_mc
// Description : Execute stage with single-cycle ALU and multi-cycle divider.
// Revision    : 1.0 - initial release
// ============================================================================
module exec_unit_mc #(
    parameter int DATA_W = 32,
    parameter int RD_W   = 5,
    parameter int CTR_W  = 3
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              flush,
    input  logic [DATA_W-1:0] A,
    input  logic [DATA_W-1:0] B,
    input  logic [2:0]        ALUctr,
    input  logic [RD_W-1:0]   DX_RD,
    input  logic [CTR_W-1:0]  DX_BranchCtr,
    input  logic [CTR_W-1:0]  DX_MemCtr,
    input  logic [DATA_W-1:0] DX_BranchAddr,
    input  logic [DATA_W-1:0] DX_RegtoMem,
    output logic              XM_valid,
    output logic [DATA_W-1:0] ALUout,
    output logic [DATA_W-1:0] ALUoutBK,
    output logic              XM_BranchTaken,
    output logic [RD_W-1:0]   XM_RD,
    output logic [CTR_W-1:0]  XM_BranchCtr,
    output logic [CTR_W-1:0]  XM_MemCtr,
    output logic [DATA_W-1:0] XM_BranchAddr,
    output logic [DATA_W-1:0] XM_RegtoMem
);
    import exec_pkg::*;

    logic [1:0]        r_state;
    logic [RD_W-1:0]   r_hold_rd;
    logic [CTR_W-1:0]  r_hold_bctr;
    logic [CTR_W-1:0]  r_hold_mctr;
    logic [DATA_W-1:0] r_hold_baddr;
    logic [DATA_W-1:0] r_hold_r2m;

    logic              w_xfer;
    logic              w_div_start;
    logic              w_div_abort;
    logic              w_div_done;
    logic [DATA_W-1:0] w_quot;
    logic [DATA_W-1:0] w_rem;
    logic [DATA_W-1:0] w_res;
    logic              w_taken;

    assign in_ready    = (r_state == ST_IDLE);
    assign w_xfer      = in_valid && in_ready && !flush;
    assign w_div_start = w_xfer && (ALUctr == OP_DIV);
    assign w_div_abort = flush && (r_state != ST_IDLE);

    div_iter #(
        .DATA_W     (DATA_W)
    ) u_div (
        .clk        (clk),
        .rst        (rst),
        .i_start    (w_div_start),
        .i_abort    (w_div_abort),
        .i_dividend (A),
        .i_divisor  (B),
        .o_done     (w_div_done),
        .o_quot     (w_quot),
        .o_rem      (w_rem)
    );

    always_comb begin
        w_res   = '0;
        w_taken = 1'b0;
        case (ALUctr)
            OP_ADD:  w_res   = A + B;
            OP_SUB:  w_res   = A - B;
            OP_SLT:  w_res   = {{(DATA_W-1){1'b0}}, ($signed(A) < $signed(B))};
            OP_BEQ:  w_taken = (A == B);
            OP_XOR:  w_res   = A ^ B;
            OP_BNE:  w_taken = (A != B);
            OP_SLTU: w_res   = {{(DATA_W-1){1'b0}}, (A < B)};
            default: w_res   = '0;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state        <= ST_IDLE;
            XM_valid       <= 1'b0;
            ALUout         <= '0;
            ALUoutBK       <= '0;
            XM_BranchTaken <= 1'b0;
            XM_RD          <= '0;
            XM_BranchCtr   <= '0;
            XM_MemCtr      <= '0;
            XM_BranchAddr  <= '0;
            XM_RegtoMem    <= '0;
            r_hold_rd      <= '0;
            r_hold_bctr    <= '0;
            r_hold_mctr    <= '0;
            r_hold_baddr   <= '0;
            r_hold_r2m     <= '0;
        end else begin
            XM_valid <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (w_div_start) begin
                        r_state      <= ST_DIV_BUSY;
                        r_hold_rd    <= DX_RD;
                        r_hold_bctr  <= DX_BranchCtr;
                        r_hold_mctr  <= DX_MemCtr;
                        r_hold_baddr <= DX_BranchAddr;
                        r_hold_r2m   <= DX_RegtoMem;
                    end else if (w_xfer) begin
                        XM_valid       <= 1'b1;
                        ALUout         <= w_res;
                        XM_BranchTaken <= w_taken;
                        XM_RD          <= DX_RD;
                        XM_BranchCtr   <= DX_BranchCtr;
                        XM_MemCtr      <= DX_MemCtr;
                        XM_BranchAddr  <= DX_BranchAddr;
                        XM_RegtoMem    <= DX_RegtoMem;
                    end
                end
                ST_DIV_BUSY: begin
                    if (flush)
                        r_state <= ST_IDLE;
                    else if (w_div_done)
                        r_state <= ST_DIV_DONE;
                end
                ST_DIV_DONE: begin
                    // The divider holds its final value here, so the result is written one cycle after the last iteration.
                    r_state <= ST_IDLE;
                    if (!flush) begin
                        XM_valid       <= 1'b1;
                        ALUout         <= w_rem;
                        ALUoutBK       <= w_quot;
                        XM_BranchTaken <= 1'b0;
                        XM_RD          <= r_hold_rd;
                        XM_BranchCtr   <= r_hold_bctr;
                        XM_MemCtr      <= r_hold_mctr;
                        XM_BranchAddr  <= r_hold_baddr;
                        XM_RegtoMem    <= r_hold_r2m;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_exec_unit_mc.sv
`default_nettype none
// ============================================================================
// Module      : tb_exec_unit_mc
// Description : Directed self-checking bench for exec_unit_mc.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_exec_unit_mc;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid, in_ready, flush;
    logic [31:0] A, B;
    logic [2:0]  ALUctr;
    logic [4:0]  DX_RD;
    logic [2:0]  DX_BranchCtr, DX_MemCtr;
    logic [31:0] DX_BranchAddr, DX_RegtoMem;
    logic        XM_valid, XM_BranchTaken;
    logic [31:0] ALUout, ALUoutBK;
    logic [4:0]  XM_RD;
    logic [2:0]  XM_BranchCtr, XM_MemCtr;
    logic [31:0] XM_BranchAddr, XM_RegtoMem;

    int n_pass  = 0;
    int n_total = 0;

    exec_unit_mc #(.DATA_W(32), .RD_W(5), .CTR_W(3)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .flush(flush),
        .A(A), .B(B), .ALUctr(ALUctr), .DX_RD(DX_RD),
        .DX_BranchCtr(DX_BranchCtr), .DX_MemCtr(DX_MemCtr),
        .DX_BranchAddr(DX_BranchAddr), .DX_RegtoMem(DX_RegtoMem),
        .XM_valid(XM_valid), .ALUout(ALUout), .ALUoutBK(ALUoutBK),
        .XM_BranchTaken(XM_BranchTaken), .XM_RD(XM_RD),
        .XM_BranchCtr(XM_BranchCtr), .XM_MemCtr(XM_MemCtr),
        .XM_BranchAddr(XM_BranchAddr), .XM_RegtoMem(XM_RegtoMem)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [2:0] op, input logic [31:0] a,
                         input logic [31:0] b, input logic [4:0] rd);
        in_valid = v; ALUctr = op; A = a; B = b; DX_RD = rd;
    endtask

    task automatic test_reset();
        rst = 1'b1; flush = 1'b0;
        drive(1'b0, 3'd0, 32'd0, 32'd0, 5'd0);
        DX_BranchCtr = 3'd0; DX_MemCtr = 3'd0; DX_BranchAddr = 32'd0; DX_RegtoMem = 32'd0;
        #1;
        n_total++; if (XM_valid !== 1'b0) $display("FAIL reset_valid got %0b want 0", XM_valid); else n_pass++;
        n_total++; if ({ALUout, ALUoutBK} !== 64'd0) $display("FAIL reset_alu got %h/%h want 0", ALUout, ALUoutBK); else n_pass++;
        n_total++; if ({XM_BranchTaken, XM_RD, XM_BranchAddr} !== 38'd0) $display("FAIL reset_xm got %b %h %h want 0", XM_BranchTaken, XM_RD, XM_BranchAddr); else n_pass++;
        step(); step();
        rst = 1'b0;
        step();
        n_total++; if (in_ready !== 1'b1) $display("FAIL reset_ready got %0b want 1", in_ready); else n_pass++;
    endtask

    task automatic test_add();
        drive(1'b1, 3'd0, 32'hFFFF_FFFF, 32'd1, 5'd7);
        step();
        drive(1'b0, 3'd0, 32'd0, 32'd0, 5'd0);
        n_total++; if (ALUout !== 32'd0) $display("FAIL add_wrap got %h want 0", ALUout); else n_pass++;
        n_total++; if (XM_RD !== 5'd7) $display("FAIL add_rd got %0d want 7", XM_RD); else n_pass++;
        n_total++; if (XM_valid !== 1'b1) $display("FAIL add_valid got %0b want 1", XM_valid); else n_pass++;
        drive(1'b1, 3'd1, 32'd3, 32'd5, 5'd2);
        step();
        n_total++; if (ALUout !== 32'hFFFF_FFFE) $display("FAIL sub got %h want fffffffe", ALUout); else n_pass++;
        drive(1'b1, 3'd5, 32'hF0F0_00FF, 32'h0FF0_0F0F, 5'd2);
        step();
        drive(1'b0, 3'd0, 32'd0, 32'd0, 5'd0);
        n_total++; if (ALUout !== 32'hFF00_0FF0) $display("FAIL xor got %h want ff000ff0", ALUout); else n_pass++;
        step();
        n_total++; if (XM_valid !== 1'b0 || ALUout !== 32'hFF00_0FF0) $display("FAIL bubble got v=%0b %h want v=0 ff000ff0", XM_valid, ALUout); else n_pass++;
    endtask

    task automatic test_slt();
        drive(1'b1, 3'd2, 32'hFFFF_FFFE, 32'd1, 5'd1);
        step();
        n_total++; if (ALUout !== 32'd1) $display("FAIL slt got %h want 1", ALUout); else n_pass++;
        drive(1'b1, 3'd7, 32'hFFFF_FFFE, 32'd1, 5'd1);
        step();
        drive(1'b0, 3'd0, 32'd0, 32'd0, 5'd0);
        n_total++; if (ALUout !== 32'd0) $display("FAIL sltu got %h want 0", ALUout); else n_pass++;
    endtask

    task automatic test_branch();
        drive(1'b1, 3'd6, 32'd5, 32'd5, 5'd0);
        step();
        n_total++; if (XM_BranchTaken !== 1'b0) $display("FAIL bne_taken got %0b want 0", XM_BranchTaken); else n_pass++;
        drive(1'b1, 3'd3, 32'd5, 32'd5, 5'd0);
        DX_BranchAddr = 32'h40;
        step();
        drive(1'b0, 3'd0, 32'd0, 32'd0, 5'd0);
        DX_BranchAddr = 32'd0;
        n_total++; if (XM_BranchTaken !== 1'b1) $display("FAIL beq_taken got %0b want 1", XM_BranchTaken); else n_pass++;
        n_total++; if (XM_BranchAddr !== 32'h40 || ALUout !== 32'd0) $display("FAIL beq_data got addr=%h alu=%h want 40/0", XM_BranchAddr, ALUout); else n_pass++;
    endtask

    task automatic test_div(input logic [31:0] a, input logic [31:0] b,
                            input logic [31:0] exp_rem, input logic [31:0] exp_quo);
        int lowcnt = 0;
        int early  = 0;
        drive(1'b1, 3'd4, a, b, 5'd3);
        DX_MemCtr = 3'd5; DX_RegtoMem = 32'hAB;
        step();
        // Keep a competing ADD asserted; it must be ignored while the divider is busy.
        drive(1'b1, 3'd0, 32'd1, 32'd1, 5'd9);
        DX_MemCtr = 3'd0; DX_RegtoMem = 32'd0;
        for (int i = 0; i < 40; i++) begin
            if (in_ready === 1'b1) break;
            lowcnt++;
            if (XM_valid !== 1'b0) early++;
            step();
        end
        drive(1'b0, 3'd0, 32'd0, 32'd0, 5'd0);
        n_total++; if (lowcnt != 33 || early != 0) $display("FAIL div_busy got %0d low cycles %0d early valids want 33/0", lowcnt, early); else n_pass++;
        n_total++; if (XM_valid !== 1'b1) $display("FAIL div_valid got %0b want 1", XM_valid); else n_pass++;
        n_total++; if (ALUout !== exp_rem || ALUoutBK !== exp_quo) $display("FAIL div_result got rem=%h quo=%h want %h/%h", ALUout, ALUoutBK, exp_rem, exp_quo); else n_pass++;
        n_total++; if (XM_RD !== 5'd3 || XM_MemCtr !== 3'd5 || XM_RegtoMem !== 32'hAB) $display("FAIL div_pass got rd=%0d mem=%0d r2m=%h want 3/5/ab", XM_RD, XM_MemCtr, XM_RegtoMem); else n_pass++;
        step();
        n_total++; if (XM_valid !== 1'b0 || ALUoutBK !== exp_quo) $display("FAIL div_after got v=%0b quo=%h want 0/%h", XM_valid, ALUoutBK, exp_quo); else n_pass++;
    endtask

    task automatic test_bk_hold();
        drive(1'b1, 3'd0, 32'd1, 32'd1, 5'd4);
        step();
        drive(1'b0, 3'd0, 32'd0, 32'd0, 5'd0);
        n_total++; if (ALUout !== 32'd2 || ALUoutBK !== 32'hFFFF_FFFF) $display("FAIL bk_hold got alu=%h bk=%h want 2/ffffffff", ALUout, ALUoutBK); else n_pass++;
    endtask

    task automatic test_flush();
        int pulses = 0;
        drive(1'b1, 3'd0, 32'd10, 32'd20, 5'd1);
        flush = 1'b1;
        step();
        flush = 1'b0;
        drive(1'b0, 3'd0, 32'd0, 32'd0, 5'd0);
        n_total++; if (XM_valid !== 1'b0 || ALUout !== 32'd2) $display("FAIL flush_idle got v=%0b alu=%h want 0/2", XM_valid, ALUout); else n_pass++;
        drive(1'b1, 3'd4, 32'd1000, 32'd3, 5'd6);
        step();
        drive(1'b0, 3'd0, 32'd0, 32'd0, 5'd0);
        for (int i = 1; i < 10; i++) step();
        flush = 1'b1;
        step();
        flush = 1'b0;
        n_total++; if (in_ready !== 1'b1 || XM_valid !== 1'b0) $display("FAIL flush_div got ready=%0b v=%0b want 1/0", in_ready, XM_valid); else n_pass++;
        for (int i = 0; i < 40; i++) begin
            if (XM_valid !== 1'b0) pulses++;
            step();
        end
        n_total++; if (pulses != 0 || ALUoutBK !== 32'hFFFF_FFFF) $display("FAIL flush_noresult got %0d pulses bk=%h want 0/ffffffff", pulses, ALUoutBK); else n_pass++;
    endtask

    task automatic test_rst_mid_div();
        int pulses = 0;
        drive(1'b1, 3'd4, 32'd77, 32'd5, 5'd8);
        step();
        drive(1'b0, 3'd0, 32'd0, 32'd0, 5'd0);
        for (int i = 1; i < 5; i++) step();
        rst = 1'b1;
        #1;
        n_total++; if ({XM_valid, XM_BranchTaken, ALUout, ALUoutBK} !== 66'd0) $display("FAIL rst_div_alu got v=%0b alu=%h bk=%h want 0", XM_valid, ALUout, ALUoutBK); else n_pass++;
        n_total++; if ({XM_RD, XM_BranchCtr, XM_MemCtr, XM_BranchAddr, XM_RegtoMem} !== 75'd0) $display("FAIL rst_div_xm got rd=%0d addr=%h r2m=%h want 0", XM_RD, XM_BranchAddr, XM_RegtoMem); else n_pass++;
        step();
        rst = 1'b0;
        for (int i = 0; i < 40; i++) begin
            if (XM_valid !== 1'b0 || in_ready !== 1'b1) pulses++;
            step();
        end
        n_total++; if (pulses != 0) $display("FAIL rst_div_after got %0d bad cycles want 0", pulses); else n_pass++;
    endtask

    task automatic test_back_to_back();
        int bad = 0;
        for (int i = 0; i < 5; i++) begin
            drive(1'b1, 3'd0, 32'(i), 32'd10, 5'(i + 1));
            step();
            if (XM_valid !== 1'b1 || ALUout !== 32'(i + 10) || XM_RD !== 5'(i + 1)) begin
                bad++;
                $display("FAIL b2b_%0d got v=%0b alu=%h rd=%0d want 1/%h/%0d", i, XM_valid, ALUout, XM_RD, i + 10, i + 1);
            end
        end
        drive(1'b0, 3'd0, 32'd0, 32'd0, 5'd0);
        n_total++; if (bad != 0) $display("FAIL back_to_back got %0d bad results want 0", bad); else n_pass++;
    endtask

    initial begin
        test_reset();
        test_add();
        test_slt();
        test_branch();
        test_div(32'd100, 32'd7, 32'd2, 32'd14);
        test_div(32'd9, 32'd0, 32'd9, 32'hFFFF_FFFF);
        test_bk_hold();
        test_flush();
        test_rst_mid_div();
        test_back_to_back();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire
